ps2_kbd_rx_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver. It filters and synchronises the PS/2 clock and data lines, deframes 11-bit frames, and checks the start, parity and stop bits. It folds the E0 (extended) and F0 (break) prefixes into single key events and buffers those events in a first-word-fall-through FIFO with a valid/ready handshake. It sits between the PS/2 pins and any consumer of key events, such as the display/terminal logic or a CPU-visible MMIO register.

---
 rtl/ps2_kbd_rx_fifo.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_kbd_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx_fifo
// Purpose  : PS/2 keyboard receiver. Synchronises and glitch-filters the PS/2
//            clock and data pins, deframes 11-bit frames (start, 8 data LSB
//            first, odd parity, stop), folds E0/F0 prefixes into single key
//            events and buffers them in a first-word-fall-through FIFO.
// Ports    : clk        - system clock
//            resetn     - synchronous active-low reset
//            ps2_clk    - asynchronous PS/2 clock pin
//            ps2_data   - asynchronous PS/2 data pin
//            ev_valid   - FIFO head holds an event
//            ev_ready   - consumer accepts the head event
//            ev_code    - scan code of head event (0 when empty)
//            ev_ext     - head event was preceded by E0
//            ev_break   - head event is a key release (preceded by F0)
//            fifo_count - number of stored events
//            overflow   - sticky: an event was dropped on a full FIFO
//            err_parity - one-cycle pulse on parity error
//            err_frame  - one-cycle pulse on bad start/stop bit or timeout
//            clr_err    - clears overflow (loses to a same-cycle set)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx_fifo #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 20000,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             err_parity,
    output logic             err_frame,
    input  logic             clr_err
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [3:0]       RUN_MAX  = 4'(FILTER_LEN - 1);
    localparam logic [3:0]       BIT_STOP = 4'd10;
    localparam logic [3:0]       BIT_ONE  = 4'd1;
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [7:0]       CODE_EXT = 8'hE0;
    localparam logic [7:0]       CODE_BRK = 8'hF0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic             filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shreg_q, shreg_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             ext_q, ext_d, brk_q, brk_d;
    logic             err_par_q, err_par_d, err_frm_q, err_frm_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [9:0]       mem_q [FIFO_DEPTH];

    logic             strobe;
    logic             push_req, push_ok, pop, full;
    logic [9:0]       push_data, head;
    logic [7:0]       data_byte;
    logic             start_bit, par_bit, stop_bit;

    // Frame fields: bits enter at the MSB and shift right, so after ten
    // strobes the start bit sits at [0] and parity at [9]. The stop bit is
    // taken straight from the synchroniser on its own strobe.
    assign start_bit = shreg_q[0];
    assign data_byte = shreg_q[8:1];
    assign par_bit   = shreg_q[9];
    assign stop_bit  = dat_s2_q;

    assign strobe   = filt_prev_q & ~filt_q;
    assign full     = (count_q == CNT_FULL);
    assign ev_valid = (count_q != '0);
    assign pop      = ev_valid & ev_ready;
    assign push_ok  = push_req & (~full | pop);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        // Synchronisers
        clk_s1_d    = ps2_clk;
        clk_s2_d    = clk_s1_q;
        dat_s1_d    = ps2_data;
        dat_s2_d    = dat_s1_q;

        // Glitch filter: follow the synchronised clock only after it has
        // disagreed for FILTER_LEN consecutive cycles.
        filt_d      = filt_q;
        run_d       = 4'd0;
        filt_prev_d = filt_q;
        if (clk_s2_q != filt_q) begin
            if (run_q == RUN_MAX) begin
                filt_d = clk_s2_q;
            end else begin
                run_d = run_q + BIT_ONE;
            end
        end

        // Deframer, timeout and prefix decoder
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        to_cnt_d  = to_cnt_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        err_par_d = 1'b0;
        err_frm_d = 1'b0;
        push_req  = 1'b0;
        push_data = {ext_q, brk_q, data_byte};

        if (strobe) begin
            // A strobe always beats a coincident timeout.
            to_cnt_d = '0;
            if (bit_cnt_q == BIT_STOP) begin
                bit_cnt_d = 4'd0;
                if (start_bit || !stop_bit) begin
                    err_frm_d = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else if (!(^{data_byte, par_bit})) begin
                    err_par_d = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else if (data_byte == CODE_EXT) begin
                    ext_d = 1'b1;
                end else if (data_byte == CODE_BRK) begin
                    brk_d = 1'b1;
                end else begin
                    push_req = 1'b1;
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                end
            end else begin
                shreg_d   = {dat_s2_q, shreg_q[9:1]};
                bit_cnt_d = bit_cnt_q + BIT_ONE;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_MAX) begin
                // Abort the frame but keep any pending prefix flags.
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
                err_frm_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_ONE;
            end
        end else begin
            to_cnt_d = '0;
        end

        // FIFO bookkeeping
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end

        // Overflow set has priority over clear in the same cycle.
        ovf_d = ovf_q;
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            run_q       <= 4'd0;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= 10'd0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            err_par_q   <= 1'b0;
            err_frm_q   <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            run_q       <= run_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            err_par_q   <= err_par_d;
            err_frm_q   <= err_frm_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Event storage needs no reset: the count masks stale entries.
    always_ff @(posedge clk) begin
        if (resetn && push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign ev_code    = ev_valid ? head[7:0] : 8'd0;
    assign ev_break   = ev_valid ? head[8]   : 1'b0;
    assign ev_ext     = ev_valid ? head[9]   : 1'b0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign err_parity = err_par_q;
    assign err_frame  = err_frm_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx_fifo
// Purpose  : Directed self-checking bench for ps2_kbd_rx_fifo. Drives PS/2
//            frames on the pins and checks events, errors and FIFO state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx_fifo;

    localparam int FL    = 4;
    localparam int TO    = 200;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int HALF  = 20;

    logic          clk = 1'b0;
    logic          resetn, ps2_clk, ps2_data, ev_ready, clr_err;
    logic          ev_valid, ev_ext, ev_break, overflow, err_parity, err_frame;
    logic [7:0]    ev_code;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    ps2_kbd_rx_fifo #(
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TO),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .err_parity(err_parity),
        .err_frame (err_frame),
        .clr_err   (clr_err)
    );

    int n_cmp = 0;
    int n_err = 0;
    int par_pulses = 0;
    int frm_pulses = 0;
    logic [9:0] evq[$];   // {ext, break, code} of each accepted event

    // Inputs change #1 after posedge, so values seen here are what the
    // next posedge acts on.
    always @(negedge clk) begin
        if (err_parity) par_pulses++;
        if (err_frame)  frm_pulses++;
        if (ev_valid && ev_ready) evq.push_back({ev_ext, ev_break, ev_code});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        if (evq.size() > 0) got = evq.pop_front();
        else                got = 10'h3FF;
        chk(tag, 32'(got), 32'(exp));
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HALF / 2);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
        tick(HALF / 2);
    endtask

    // Bits 0..9 of a frame: start, data LSB first, odd parity (optionally flipped).
    function automatic logic [9:0] frame_bits(input logic [7:0] code, input logic flip_par);
        return {~(^code) ^ flip_par, code, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] code, input logic flip_par, input logic stop);
        logic [9:0] fb;
        fb = frame_bits(code, flip_par);
        for (int i = 0; i < 10; i++) send_bit(fb[i]);
        send_bit(stop);
        ps2_data = 1'b1;
    endtask

    initial begin
        logic [9:0] fb;
        int p0, f0;

        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        resetn   = 1'b0;
        ev_ready = 1'b0;
        clr_err  = 1'b0;
        tick(3);

        // Reset state
        chk("rst_valid",  32'(ev_valid),   32'd0);
        chk("rst_code",   32'(ev_code),    32'd0);
        chk("rst_ext",    32'(ev_ext),     32'd0);
        chk("rst_break",  32'(ev_break),   32'd0);
        chk("rst_count",  32'(fifo_count), 32'd0);
        chk("rst_ovf",    32'(overflow),   32'd0);
        chk("rst_perr",   32'(err_parity), 32'd0);
        chk("rst_ferr",   32'(err_frame),  32'd0);
        resetn = 1'b1;
        tick(5);

        // Single 0x1C frame; no event before the stop bit
        fb = frame_bits(8'h1C, 1'b0);
        chk("t1_bits", 32'(fb), 32'h038);
        for (int i = 0; i < 10; i++) send_bit(fb[i]);
        chk("t1_valid_pre", 32'(ev_valid), 32'd0);
        send_bit(1'b1);
        chk("t1_valid",  32'(ev_valid),   32'd1);
        chk("t1_code",   32'(ev_code),    32'h1C);
        chk("t1_ext",    32'(ev_ext),     32'd0);
        chk("t1_break",  32'(ev_break),   32'd0);
        chk("t1_count",  32'(fifo_count), 32'd1);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        tick(1);
        chk("t1_count_pop", 32'(fifo_count), 32'd0);
        chk("t1_valid_pop", 32'(ev_valid),   32'd0);
        chk("t1_code_empty", 32'(ev_code),   32'd0);
        evq.delete();

        // Prefix folding
        ev_ready = 1'b1;
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        tick(5);
        chk("t2_nev", 32'(evq.size()), 32'd3);
        chk_ev("t2_ev0", 10'h11C);
        chk_ev("t2_ev1", 10'h275);
        chk_ev("t2_ev2", 10'h375);

        // Parity error, then clean flags afterwards; reversed prefix order
        p0 = par_pulses;
        f0 = frm_pulses;
        send_frame(8'h1C, 1'b1, 1'b1);
        tick(2);
        chk("t3_perr", 32'(par_pulses - p0), 32'd1);
        chk("t3_ferr", 32'(frm_pulses - f0), 32'd0);
        chk("t3_noev", 32'(evq.size()),      32'd0);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        tick(5);
        chk_ev("t3_ev_brk",   10'h11C);
        chk_ev("t3_ev_plain", 10'h01C);
        chk_ev("t3_ev_f0e0",  10'h375);

        // Bad stop bit
        p0 = par_pulses;
        f0 = frm_pulses;
        send_frame(8'h1C, 1'b0, 1'b0);
        tick(2);
        chk("stop_ferr", 32'(frm_pulses - f0), 32'd1);
        chk("stop_perr", 32'(par_pulses - p0), 32'd0);
        chk("stop_noev", 32'(evq.size()),      32'd0);

        // Timeout after six bits
        f0 = frm_pulses;
        fb = frame_bits(8'h32, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(fb[i]);
        ps2_data = 1'b1;
        tick(TO + 100);
        chk("to_ferr", 32'(frm_pulses - f0), 32'd1);
        send_frame(8'h32, 1'b0, 1'b1);
        tick(5);
        chk_ev("to_next_ev", 10'h032);
        chk("to_ferr_after", 32'(frm_pulses - f0), 32'd1);

        // Overflow with a 4-deep FIFO
        ev_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h13, 1'b0, 1'b1);
        send_frame(8'h14, 1'b0, 1'b1);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        send_frame(8'h15, 1'b0, 1'b1);
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_flag",  32'(overflow),   32'd1);
        chk("ovf_head",  32'(ev_code),    32'h11);
        ev_ready = 1'b1;
        tick(8);
        ev_ready = 1'b0;
        chk("ovf_nev", 32'(evq.size()), 32'd4);
        chk_ev("ovf_ev0", 10'h011);
        chk_ev("ovf_ev1", 10'h012);
        chk_ev("ovf_ev2", 10'h013);
        chk_ev("ovf_ev3", 10'h014);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Glitch of FILTER_LEN-1 cycles during a frame must be ignored
        ev_ready = 1'b1;
        p0 = par_pulses;
        f0 = frm_pulses;
        fb = frame_bits(8'h1C, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(fb[i]);
        ps2_clk = 1'b0;
        tick(FL - 1);
        ps2_clk = 1'b1;
        tick(HALF);
        for (int i = 5; i < 10; i++) send_bit(fb[i]);
        send_bit(1'b1);
        tick(5);
        chk("gl_perr", 32'(par_pulses - p0), 32'd0);
        chk("gl_ferr", 32'(frm_pulses - f0), 32'd0);
        chk_ev("gl_ev", 10'h01C);

        // Reset mid-prefix and mid-frame discards everything
        ev_ready = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("mr_count_pre", 32'(fifo_count), 32'd1);
        send_frame(8'hF0, 1'b0, 1'b1);
        fb = frame_bits(8'h32, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(fb[i]);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        chk("mr_count", 32'(fifo_count), 32'd0);
        chk("mr_valid", 32'(ev_valid),   32'd0);
        chk("mr_code",  32'(ev_code),    32'd0);
        tick(5);
        f0 = frm_pulses;
        send_frame(8'h32, 1'b0, 1'b1);
        chk("mr_count_after", 32'(fifo_count), 32'd1);
        chk("mr_code_after",  32'(ev_code),    32'h32);
        chk("mr_break_after", 32'(ev_break),   32'd0);
        chk("mr_ext_after",   32'(ev_ext),     32'd0);
        chk("mr_ferr",        32'(frm_pulses - f0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
